// File: rtl/eth_sw_pkg.sv
// rtl/eth_sw_pkg.sv - shared types and constants for the 2x2 switch
package eth_sw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int PORT_A     = 0;
    localparam int PORT_B     = 1;
    localparam int PORT_COUNT = 2;

endpackage

// File: rtl/eth_sw_rd_arbiter_if.sv
// rtl/eth_sw_rd_arbiter_if.sv - ingress FIFO / crossbar handshake bundle for the read arbiter
interface eth_sw_rd_arbiter_if;
    import eth_sw_pkg::*;

    logic [PORT_COUNT-1:0] fifo_empty;
    logic [PORT_COUNT-1:0] fifo_valid;
    logic [PORT_COUNT-1:0] head_dest;
    logic [PORT_COUNT-1:0] out_ready;
    logic [PORT_COUNT-1:0] rd_en;
    logic                  fwd_strobe;
    logic                  fwd_src;

    modport master (
        input  fifo_empty,
        input  fifo_valid,
        input  head_dest,
        input  out_ready,
        output rd_en,
        output fwd_strobe,
        output fwd_src
    );

    modport slave (
        output fifo_empty,
        output fifo_valid,
        output head_dest,
        output out_ready,
        input  rd_en,
        input  fwd_strobe,
        input  fwd_src
    );

endinterface

// File: rtl/eth_rr_pick.sv
// rtl/eth_rr_pick.sv - combinational two-requester round-robin picker
module eth_rr_pick (
    input  logic [1:0] elig,
    input  logic       last_grant,
    output logic       any,
    output logic       g
);

    // Prefer the port that did not win last; otherwise the lone requester.
    always_comb begin
        any = |elig;
        g   = elig[~last_grant] ? ~last_grant : last_grant;
    end

endmodule

// File: rtl/eth_sw_rd_arbiter.sv
// rtl/eth_sw_rd_arbiter.sv - ingress FIFO read scheduler with round-robin grant and statistics
module eth_sw_rd_arbiter
    import eth_sw_pkg::*;
#(
    parameter int TIMEOUT   = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 arb_en,
    eth_sw_rd_arbiter_if.master  arb,
    output logic                 err_timeout,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] gnt_cnt_a,
    output logic [CNT_WIDTH-1:0] gnt_cnt_b
);

    localparam int WCW = $clog2(TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    arb_state_e            state, state_n;
    logic                  last_grant, last_grant_n;
    logic [WCW-1:0]        wait_cnt, wait_cnt_n;
    logic [PORT_COUNT-1:0] rd_en_q, rd_en_n;
    logic                  strobe_q, strobe_n;
    logic                  src_q, src_n;
    logic                  err_n, busy_n;
    logic [CNT_WIDTH-1:0]  cnt_a_n, cnt_b_n;

    logic [PORT_COUNT-1:0] elig;
    logic                  any;
    logic                  g;

    // A head packet is only worth reading if its egress port can take it.
    always_comb begin
        elig = '0;
        for (int i = PORT_A; i < PORT_COUNT; i++) begin
            elig[i] = ~arb.fifo_empty[i] & arb.out_ready[arb.head_dest[i]];
        end
    end

    eth_rr_pick u_pick (
        .elig       (elig),
        .last_grant (last_grant),
        .any        (any),
        .g          (g)
    );

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        wait_cnt_n   = wait_cnt;
        rd_en_n      = '0;
        strobe_n     = 1'b0;
        src_n        = src_q;
        err_n        = 1'b0;
        cnt_a_n      = gnt_cnt_a;
        cnt_b_n      = gnt_cnt_b;

        case (state)
            IDLE: begin
                if (arb_en && any) begin
                    rd_en_n      = g ? 2'b10 : 2'b01;
                    src_n        = g;
                    last_grant_n = g;
                    wait_cnt_n   = '0;
                    state_n      = WAIT;
                end
            end
            WAIT: begin
                // Valid takes priority over an expiring timeout in the same cycle.
                if (arb.fifo_valid[src_q]) begin
                    strobe_n = 1'b1;
                    if (src_q) begin
                        if (gnt_cnt_b != '1) cnt_b_n = gnt_cnt_b + CNT_WIDTH'(1);
                    end else begin
                        if (gnt_cnt_a != '1) cnt_a_n = gnt_cnt_a + CNT_WIDTH'(1);
                    end
                    state_n = GAP;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_n   = 1'b1;
                    state_n = GAP;
                end else begin
                    wait_cnt_n = wait_cnt + WCW'(1);
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            wait_cnt    <= '0;
            rd_en_q     <= '0;
            strobe_q    <= 1'b0;
            src_q       <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
            gnt_cnt_a   <= '0;
            gnt_cnt_b   <= '0;
        end else begin
            state       <= state_n;
            last_grant  <= last_grant_n;
            wait_cnt    <= wait_cnt_n;
            rd_en_q     <= rd_en_n;
            strobe_q    <= strobe_n;
            src_q       <= src_n;
            err_timeout <= err_n;
            busy        <= busy_n;
            gnt_cnt_a   <= cnt_a_n;
            gnt_cnt_b   <= cnt_b_n;
        end
    end

    assign arb.rd_en      = rd_en_q;
    assign arb.fwd_strobe = strobe_q;
    assign arb.fwd_src    = src_q;

endmodule

// File: tb/tb_eth_sw_rd_arbiter.sv
// tb/tb_eth_sw_rd_arbiter.sv - directed self-checking bench for eth_sw_rd_arbiter
module tb_eth_sw_rd_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic arb_en = 1'b0;
    logic arb_en2 = 1'b0;
    logic err_timeout, busy, err_timeout2, busy2;
    logic [15:0] gnt_cnt_a, gnt_cnt_b;
    logic [1:0]  gnt_cnt_a2, gnt_cnt_b2;
    logic [1:0]  rd_d = 2'b00;
    logic [1:0]  rd_d2 = 2'b00;
    logic [1:0]  valid_mask = 2'b11;
    int vec = 0;
    int errs = 0;

    eth_sw_rd_arbiter_if bus ();
    eth_sw_rd_arbiter_if bus2 ();

    always #5 clk = ~clk;

    // FIFO model: data_out valid one cycle after it samples rd_en.
    always @(posedge clk) begin
        rd_d  <= bus.rd_en;
        rd_d2 <= bus2.rd_en;
    end
    assign bus.fifo_valid  = rd_d & valid_mask;
    assign bus2.fifo_valid = rd_d2;

    eth_sw_rd_arbiter #(.TIMEOUT(8), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .arb_en      (arb_en),
        .arb         (bus),
        .err_timeout (err_timeout),
        .busy        (busy),
        .gnt_cnt_a   (gnt_cnt_a),
        .gnt_cnt_b   (gnt_cnt_b)
    );

    eth_sw_rd_arbiter #(.TIMEOUT(8), .CNT_WIDTH(2)) dut2 (
        .clk         (clk),
        .rstn        (rstn),
        .arb_en      (arb_en2),
        .arb         (bus2),
        .err_timeout (err_timeout2),
        .busy        (busy2),
        .gnt_cnt_a   (gnt_cnt_a2),
        .gnt_cnt_b   (gnt_cnt_b2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        bus.fifo_empty = 2'b11; bus.head_dest = 2'b10; bus.out_ready = 2'b11;
        bus2.fifo_empty = 2'b11; bus2.head_dest = 2'b10; bus2.out_ready = 2'b11;
        arb_en = 1'b1;
        do_reset();
        vec++;
        if ({bus.rd_en, bus.fwd_strobe, bus.fwd_src, err_timeout, busy} !== 6'b0) begin
            errs++;
            $display("FAIL reset_outputs: got rd_en=%b strobe=%b src=%b err=%b busy=%b, need all 0",
                     bus.rd_en, bus.fwd_strobe, bus.fwd_src, err_timeout, busy);
        end
        vec++;
        if (gnt_cnt_a !== 16'd0 || gnt_cnt_b !== 16'd0) begin
            errs++;
            $display("FAIL reset_counters: got a=%0d b=%0d, need 0/0", gnt_cnt_a, gnt_cnt_b);
        end
    endtask

    task automatic test_single();
        logic [3:0] busy_seq;
        do_reset();
        bus.fifo_empty = 2'b10; bus.head_dest = 2'b01; bus.out_ready = 2'b11;
        valid_mask = 2'b11; arb_en = 1'b1;
        tick();
        busy_seq[0] = busy;
        vec++;
        if (bus.rd_en !== 2'b01 || bus.fwd_src !== 1'b0) begin
            errs++;
            $display("FAIL single_grant: got rd_en=%b src=%b, need 01/0", bus.rd_en, bus.fwd_src);
        end
        bus.fifo_empty = 2'b11;
        tick();
        busy_seq[1] = busy;
        vec++;
        if (bus.rd_en !== 2'b00 || bus.fwd_strobe !== 1'b0) begin
            errs++;
            $display("FAIL single_rd_pulse: got rd_en=%b strobe=%b, need 00/0", bus.rd_en, bus.fwd_strobe);
        end
        tick();
        busy_seq[2] = busy;
        vec++;
        if (bus.fwd_strobe !== 1'b1 || bus.fwd_src !== 1'b0 || gnt_cnt_a !== 16'd1 || gnt_cnt_b !== 16'd0) begin
            errs++;
            $display("FAIL single_strobe: got strobe=%b src=%b a=%0d b=%0d, need 1/0/1/0",
                     bus.fwd_strobe, bus.fwd_src, gnt_cnt_a, gnt_cnt_b);
        end
        tick();
        busy_seq[3] = busy;
        vec++;
        if (busy_seq !== 4'b0111 || bus.fwd_strobe !== 1'b0) begin
            errs++;
            $display("FAIL single_busy: got busy seq(3..0)=%b strobe=%b, need 0111/0", busy_seq, bus.fwd_strobe);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int last = 0;
        logic exp_src = 1'b0;
        do_reset();
        bus.fifo_empty = 2'b00; bus.head_dest = 2'b10; bus.out_ready = 2'b11;
        valid_mask = 2'b11; arb_en = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (bus.rd_en !== 2'b00) begin
                n++;
                vec++;
                if (bus.rd_en !== (exp_src ? 2'b10 : 2'b01) || bus.fwd_src !== exp_src) begin
                    errs++;
                    $display("FAIL b2b_grant%0d: got rd_en=%b src=%b, need src=%b one-hot", n, bus.rd_en, bus.fwd_src, exp_src);
                end
                if (n > 1) begin
                    vec++;
                    if (cyc - last != 4) begin
                        errs++;
                        $display("FAIL b2b_spacing%0d: got %0d cycles, need 4", n, cyc - last);
                    end
                end
                last = cyc;
                exp_src = ~exp_src;
                if (n == 4) bus.fifo_empty = 2'b11;
            end
        end
        vec++;
        if (n != 4 || gnt_cnt_a !== 16'd2 || gnt_cnt_b !== 16'd2) begin
            errs++;
            $display("FAIL b2b_counts: got grants=%0d a=%0d b=%0d, need 4/2/2", n, gnt_cnt_a, gnt_cnt_b);
        end
    endtask

    task automatic test_eligibility();
        int bad = 0;
        int seen = 0;
        do_reset();
        bus.fifo_empty = 2'b00; bus.head_dest = 2'b00; bus.out_ready = 2'b10;
        valid_mask = 2'b11; arb_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.rd_en !== 2'b00 || busy !== 1'b0) bad++;
        end
        vec++;
        if (bad != 0) begin
            errs++;
            $display("FAIL elig_blocked: got %0d cycles with a grant, need 0", bad);
        end
        bus.head_dest = 2'b10;
        tick();
        vec++;
        if (bus.rd_en !== 2'b10 || bus.fwd_src !== 1'b1) begin
            errs++;
            $display("FAIL elig_b_grant: got rd_en=%b src=%b, need 10/1", bus.rd_en, bus.fwd_src);
        end
        bus.out_ready = 2'b11;
        for (int i = 0; i < 6 && seen == 0; i++) begin
            tick();
            if (bus.rd_en !== 2'b00) seen = 1;
        end
        vec++;
        if (seen == 0 || bus.rd_en !== 2'b01) begin
            errs++;
            $display("FAIL elig_a_next: got rd_en=%b seen=%0d, need 01 within 6 cycles", bus.rd_en, seen);
        end
        bus.fifo_empty = 2'b11;
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        int early = 0;
        do_reset();
        bus.fifo_empty = 2'b10; bus.head_dest = 2'b10; bus.out_ready = 2'b11;
        valid_mask = 2'b00; arb_en = 1'b1;
        tick();
        vec++;
        if (bus.rd_en !== 2'b01) begin
            errs++;
            $display("FAIL to_grant_a: got rd_en=%b, need 01", bus.rd_en);
        end
        bus.fifo_empty = 2'b00;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (err_timeout !== 1'b0 || bus.fwd_strobe !== 1'b0 || busy !== 1'b1) early++;
        end
        vec++;
        if (early != 0) begin
            errs++;
            $display("FAIL to_early: got %0d bad cycles before 8th wait edge, need 0", early);
        end
        tick();
        vec++;
        if (err_timeout !== 1'b1 || bus.fwd_strobe !== 1'b0 || gnt_cnt_a !== 16'd0 || gnt_cnt_b !== 16'd0) begin
            errs++;
            $display("FAIL to_pulse: got err=%b strobe=%b a=%0d b=%0d, need 1/0/0/0",
                     err_timeout, bus.fwd_strobe, gnt_cnt_a, gnt_cnt_b);
        end
        tick();
        vec++;
        if (err_timeout !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL to_idle: got err=%b busy=%b, need 0/0", err_timeout, busy);
        end
        tick();
        vec++;
        if (bus.rd_en !== 2'b10) begin
            errs++;
            $display("FAIL to_next_b: got rd_en=%b, need 10", bus.rd_en);
        end
        valid_mask = 2'b11;
        bus.fifo_empty = 2'b11;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        bus.fifo_empty = 2'b00; bus.head_dest = 2'b10; bus.out_ready = 2'b11;
        valid_mask = 2'b11; arb_en = 1'b1;
        for (int i = 0; i < 20 && n < 3; i++) begin
            tick();
            if (bus.rd_en !== 2'b00) n++;
        end
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        vec++;
        if (n != 3 || bus.rd_en !== 2'b00 || busy !== 1'b0 || bus.fwd_strobe !== 1'b0 ||
            gnt_cnt_a !== 16'd0 || gnt_cnt_b !== 16'd0) begin
            errs++;
            $display("FAIL rst_mid: got grants=%0d rd_en=%b busy=%b strobe=%b a=%0d b=%0d, need 3/00/0/0/0/0",
                     n, bus.rd_en, busy, bus.fwd_strobe, gnt_cnt_a, gnt_cnt_b);
        end
        tick();
        vec++;
        if (bus.rd_en !== 2'b01) begin
            errs++;
            $display("FAIL rst_first_a: got rd_en=%b, need 01", bus.rd_en);
        end
        bus.fifo_empty = 2'b11;
        repeat (4) tick();
    endtask

    task automatic test_saturation();
        int n = 0;
        int leaked = 0;
        bus.fifo_empty = 2'b11;
        do_reset();
        bus2.fifo_empty = 2'b10; bus2.head_dest = 2'b00; bus2.out_ready = 2'b11;
        arb_en2 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus2.fwd_strobe === 1'b1) n++;
            if (bus2.rd_en !== 2'b00 && n == 4) arb_en2 = 1'b0;
        end
        vec++;
        if (n != 5 || gnt_cnt_a2 !== 2'd3 || gnt_cnt_b2 !== 2'd0) begin
            errs++;
            $display("FAIL sat_count: got strobes=%0d a=%0d b=%0d, need 5/3/0", n, gnt_cnt_a2, gnt_cnt_b2);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus2.rd_en !== 2'b00 || busy2 !== 1'b0) leaked++;
        end
        vec++;
        if (leaked != 0) begin
            errs++;
            $display("FAIL sat_arb_off: got %0d active cycles with arb_en=0, need 0", leaked);
        end
    endtask

    initial begin
        bus.fifo_empty = 2'b11; bus.head_dest = 2'b00; bus.out_ready = 2'b00;
        bus2.fifo_empty = 2'b11; bus2.head_dest = 2'b00; bus2.out_ready = 2'b00;
        test_reset();
        test_single();
        test_back_to_back();
        test_eligibility();
        test_timeout();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/eth_sw_rd_arbiter.md
Name: eth_sw_rd_arbiter

Overview:
- Read scheduler for the two ingress port FIFOs of the 2x2 Ethernet switch.
- Generates the per-port FIFO rd_en so that at most one FIFO is read per transaction; the both-ports read case is impossible by construction.
- Arbitrates round-robin among non-empty FIFOs whose head packet's destination output is ready.
- Emits a forward strobe when the read data is valid, and keeps per-port grant statistics.

Parameters:
TIMEOUT, 8, max cycles in WAIT for fifo_valid before abort (>=2)
CNT_WIDTH, 16, width of saturating per-port grant counters

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
arb_en  in  1  1 = new grants allowed; 0 = no new grants, in-flight transaction completes
fifo_empty  in  2  empty flag per ingress FIFO, [0]=A, [1]=B
fifo_valid  in  2  per-FIFO data_out valid, asserted one cycle after a sampled rd_en
head_dest  in  2  destination output of each FIFO's head packet, 0=A, 1=B (decoded by parent)
out_ready  in  2  egress output port can accept a packet, [0]=A, [1]=B
rd_en  out  2  FIFO read enables; one-hot or zero, registered, one-cycle pulse
fwd_strobe  out  1  one-cycle pulse: granted FIFO data is valid; crossbar forwards it
fwd_src  out  1  source port of the current/last grant (0=A, 1=B)
err_timeout  out  1  one-cycle pulse: fifo_valid not seen within TIMEOUT cycles
busy  out  1  1 whenever state != IDLE
gnt_cnt_a  out  CNT_WIDTH  saturating count of completed grants from port A
gnt_cnt_b  out  CNT_WIDTH  saturating count of completed grants from port B

Behaviour:
- Reset values (rstn=0 at a rising edge):
  - rd_en=0, fwd_strobe=0, err_timeout=0, busy=0, fwd_src=0.
  - gnt_cnt_a=gnt_cnt_b=0, wait counter=0.
  - state=IDLE, last_grant=1, so the first grant goes to A.
- Reset mid-transaction aborts immediately: no strobe, no counter update.
- Eligibility, computed combinationally: elig[i] = ~fifo_empty[i] & out_ready[head_dest[i]].
- State machine IDLE, WAIT, GAP:
  - IDLE:
    - If arb_en & |elig: g = elig[~last_grant] ? ~last_grant : the single eligible port.
    - At that edge: rd_en[g]<=1, fwd_src<=g, last_grant<=g, wait counter<=0, state<=WAIT.
    - Otherwise stay in IDLE with rd_en=0.
  - WAIT:
    - rd_en<=0 at the first WAIT edge, so rd_en is high for exactly one cycle.
    - If fifo_valid[fwd_src]=1: fwd_strobe<=1, increment the granted port's counter (saturate at all-ones), state<=GAP.
    - Else if wait counter==TIMEOUT-1: err_timeout<=1, no counter update, state<=GAP.
    - Else wait counter++.
  - GAP:
    - Exactly one cycle; fwd_strobe and err_timeout return to 0; state<=IDLE.
    - Covers the egress one-cycle sop/eop hold and lets fifo_empty update before the next eligibility sample.
- Minimum spacing between consecutive rd_en pulses: 4 cycles (rd_en edge, valid edge, GAP, IDLE).
- Round-robin:
  - With both ports continuously eligible, grants alternate A,B,A,B.
  - A single eligible port is granted back-to-back regardless of last_grant.
- fifo_valid of the non-granted port is ignored.
- Changes to out_ready or fifo_empty after the grant do not affect the in-flight transaction.
- arb_en deasserted in WAIT/GAP: transaction completes normally; no new grant while arb_en=0.
- fifo_valid and timeout in the same cycle: valid wins (strobe, no err_timeout).
- Counter saturation: at all-ones, further grants leave the value unchanged.
- busy=1 in WAIT and GAP, 0 in IDLE; registered from next state.

Decomposition:
- Shared package eth_sw_pkg:
  - arb_state_e enum {IDLE, WAIT, GAP}
  - PORT_A=0, PORT_B=1, PORT_COUNT=2
- One sub-module, eth_rr_pick: combinational 2-requester round-robin picker.
  - Inputs: elig[1:0], last_grant.
  - Outputs: any, g.
  - Reused by the future egress-side arbiter.

Test Plan:
1. Only A non-empty, head_dest[0]=1, out_ready=2'b11, fifo_valid[0] returned 1 cycle after rd_en -> rd_en=2'b01 for one cycle; fwd_strobe one cycle later with fwd_src=0; gnt_cnt_a=1, gnt_cnt_b=0; busy high for 3 cycles.
2. Both FIFOs non-empty throughout, all outputs ready, 4 transactions -> fwd_src sequence 0,1,0,1; rd_en never 2'b11; pulses 4 cycles apart; gnt_cnt_a=gnt_cnt_b=2.
3. head_dest=2'b00, out_ready=2'b10, both non-empty -> no grant; head_dest[1] changed to 1 -> B granted; then out_ready=2'b11 -> A granted next.
4. TIMEOUT=8, A granted, fifo_valid held 0 -> err_timeout pulse at the 8th WAIT edge; no fwd_strobe; counters unchanged; IDLE after GAP; next grant to B if eligible.
5. rstn=0 for one edge while in WAIT -> next cycle rd_en=0, busy=0, counters 0; with both eligible after release, first grant is A.
6. CNT_WIDTH=2, arb_en=1, only A eligible, 5 completed transactions -> gnt_cnt_a=3; then arb_en=0 with A non-empty -> rd_en stays 0 for 20 cycles.
